clock_cen_sequencer: RTL
========================

// Module: clock_cen_sequencer
// PURPOSE
//  Sequences the CEN input of one global CLOCK cell that several fabric
//  requesters share. Requester clock needs are OR-combined into CEN, and
//  each requester gets a grant only after a programmable wake-up settle time.
//  CEN is held for a hold-off time after the last request drops.
//  Sits in fabric next to the CLOCK cell and runs on an always-on clock.
// PARAMETERS
//  N_REQ     4   number of requesters, 1..8
//  WAKE_CYC  8   CLK cycles from CEN rise to first grant, 1..255
//  HOLD_CYC  16  idle CLK cycles before CEN fall, 0..255
// PORTS
//  CLK       in   1      always-on control clock
//  RST_N     in   1      asynchronous active-low reset
//  REQ       in   N_REQ  level request per requester; one bit per requester
//  FORCE_ON  in   1      keep CEN high regardless of REQ (test/debug)
//  GNT       out  N_REQ  registered grant: clock stable for that requester
//  CEN       out  1      registered enable to the CLOCK cell
//  BUSY      out  1      high in WAKE or HOLD (transitional states)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=OFF, CEN=0, GNT=0, BUSY=0,
//    counter=0.
//  - any_req = |REQ | FORCE_ON. Counter width is 8 bits.
//  - FSM, one transition per CLK:
//    OFF : any_req -> WAKE, CEN<=1, cnt<=WAKE_CYC-1.
//    WAKE: cnt!=0 -> cnt-1. cnt==0 -> ON, whether or not any_req is still
//          high. A wake sequence is never aborted, so CEN never glitches.
//    ON  : GNT<=REQ, updated every cycle. !any_req -> HOLD, cnt<=HOLD_CYC;
//          if HOLD_CYC==0, go directly to OFF with CEN<=0.
//    HOLD: any_req -> ON with no wake delay; GNT<=REQ on the next edge.
//          Else cnt!=0 -> cnt-1; cnt==0 -> OFF, CEN<=0.
//  - GNT is 0 in OFF, WAKE and HOLD. In ON, GNT[i] follows REQ[i] with
//    1-cycle latency. Dropping REQ[i] clears GNT[i] on the next edge.
//  - Latency from REQ rise in OFF: CEN high after 1 edge; GNT high after
//    WAKE_CYC+2 edges.
//  - REQ and FORCE_ON rising and falling in the same cycle: evaluated as
//    a level only; the value on that edge wins.
//  - FORCE_ON holds the FSM in ON but grants still follow REQ only.
//  - Reset asserted mid-WAKE or mid-HOLD: CEN drops at once (async).
//    This is the only permitted unsequenced CEN fall.
//  - BUSY = (state==WAKE)|(state==HOLD), registered with the state.
//  - All outputs come from flops; no combinational REQ->GNT path.
// STRUCTURE
//  - Shared package clock_ctrl_pkg:
//    - state enum {OFF=2'd0, WAKE=2'd1, ON=2'd2, HOLD=2'd3}
//    - CNT_W=8
//    - parameter range checks
//  - Sub-module clock_cen_timer: loadable 8-bit down-counter.
//    Ports load, load_val, dec, zero.
//    Both WAKE and HOLD reuse it.
//  - Top holds the FSM, the grant register and the output flops.
//  - CEN drives the CLOCK cell CEN pin directly.
// TESTING
//  1. Reset with REQ=4'b0001 held -> CEN=0 and GNT=0 during reset; after
//     release, CEN=1 at edge 1 and GNT=4'b0001 at edge WAKE_CYC+2=10.
//  2. In ON with REQ=4'b0011, drop all REQ -> GNT=0 next edge, BUSY=1;
//     CEN falls exactly 17 edges later (HOLD_CYC=16).
//  3. In HOLD with cnt=5, raise REQ=4'b0100 -> ON next edge, GNT=4'b0100
//     the edge after, CEN never drops.
//  4. In WAKE with cnt=3, drop REQ -> WAKE completes, passes ON for one
//     cycle with GNT=0, then HOLD; CEN stays high without a glitch.
//  5. FORCE_ON=1, REQ=0 -> CEN=1 indefinitely and GNT=0; set REQ=4'b1000
//     -> GNT=4'b1000 after one edge.
//  6. Assert RST_N low mid-HOLD -> CEN, GNT and BUSY go to 0 asynchronously
//     before the next CLK edge; the FSM restarts in OFF.
//     Also rerun with HOLD_CYC=0 -> CEN falls on the edge after the
//     last REQ drops.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and parameter checks for the global clock CEN sequencer.
package clock_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } state_e;

  function automatic bit params_ok(input int n_req, input int wake_cyc, input int hold_cyc);
    return (n_req >= 1) && (n_req <= 8) &&
           (wake_cyc >= 1) && (wake_cyc <= 255) &&
           (hold_cyc >= 0) && (hold_cyc <= 255);
  endfunction

endpackage

// File: rtl/clock_cen_timer.sv
// Loadable down-counter shared by the wake-up settle and hold-off phases.
module clock_cen_timer
  import clock_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (dec)  cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clock_cen_sequencer.sv
// OR-combines requester clock needs into CEN of one CLOCK cell, granting
// each requester only once the clock has settled.
module clock_cen_sequencer
  import clock_ctrl_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WAKE_CYC = 8,
  parameter int HOLD_CYC = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] REQ,
  input  logic             FORCE_ON,
  output logic [N_REQ-1:0] GNT,
  output logic             CEN,
  output logic             BUSY
);

  if (!params_ok(N_REQ, WAKE_CYC, HOLD_CYC)) begin : g_bad_params
    $error("clock_cen_sequencer: parameter out of range");
  end

  state_e           state_q, state_d;
  logic             cen_d, busy_d;
  logic [N_REQ-1:0] gnt_d;
  logic             any_req;
  logic             t_load, t_dec, t_zero;
  logic [CNT_W-1:0] t_load_val;

  assign any_req = (|REQ) | FORCE_ON;

  clock_cen_timer u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_comb begin
    state_d    = state_q;
    cen_d      = CEN;
    t_load     = 1'b0;
    t_load_val = '0;
    t_dec      = 1'b0;
    case (state_q)
      OFF: if (any_req) begin
        state_d    = WAKE;
        cen_d      = 1'b1;
        t_load     = 1'b1;
        t_load_val = CNT_W'(WAKE_CYC - 1);
      end
      // A wake sequence always runs to completion so CEN cannot glitch.
      WAKE: if (t_zero) state_d = ON;
            else        t_dec   = 1'b1;
      ON: if (!any_req) begin
        if (HOLD_CYC == 0) begin
          state_d = OFF;
          cen_d   = 1'b0;
        end else begin
          state_d    = HOLD;
          t_load     = 1'b1;
          t_load_val = CNT_W'(HOLD_CYC);
        end
      end
      HOLD: if (any_req) state_d = ON;
            else if (t_zero) begin
              state_d = OFF;
              cen_d   = 1'b0;
            end else t_dec = 1'b1;
      default: state_d = OFF;
    endcase
    gnt_d  = (state_q == ON) ? REQ : '0;
    busy_d = (state_d == WAKE) || (state_d == HOLD);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= OFF;
      CEN     <= 1'b0;
      GNT     <= '0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      CEN     <= cen_d;
      GNT     <= gnt_d;
      BUSY    <= busy_d;
    end
  end

endmodule
